round_scheduler: RTL and testbench

Sequencing controller for the 4-player pairwise comparator (x2/x1/x0 per player pair). On a start request it latches the four 3-bit plays, time-multiplexes one shared comparator over the six pairs in a fixed order, and accumulates per-player scores. It then declares the winner set. It sits between the player-input stage and the result display, and replaces six parallel comparator instances with one.

---
 rtl/round_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_round_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/round_scheduler.sv
// Round controller that time-multiplexes one pairwise comparator over the six
// player pairs of a 4-player round, accumulating scores and picking winners.
module round_scheduler #(
  parameter int PW      = 3,
  parameter int WIN_PTS = 2,
  parameter int TIE_PTS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] J1,
  input  logic [PW-1:0] J2,
  input  logic [PW-1:0] J3,
  input  logic [PW-1:0] J4,
  output logic [PW-1:0] op_a,
  output logic [PW-1:0] op_b,
  output logic [2:0]    pair_idx,
  input  logic [2:0]    cmp_res,
  output logic          busy,
  output logic          done,
  output logic [2:0]    score1,
  output logic [2:0]    score2,
  output logic [2:0]    score3,
  output logic [2:0]    score4,
  output logic [3:0]    winners,
  output logic          err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PAIR   = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Point values clamped so oversized parameters still fit the score width
  localparam logic [2:0] WIN3 = (WIN_PTS > 7) ? 3'd7 : 3'(WIN_PTS);
  localparam logic [2:0] TIE3 = (TIE_PTS > 7) ? 3'd7 : 3'(TIE_PTS);

  logic [1:0]    r_state;
  logic [PW-1:0] r_play [4];
  logic [2:0]    r_score [4];
  logic [PW-1:0] r_op_a;
  logic [PW-1:0] r_op_b;
  logic [2:0]    r_pair_idx;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_winners;
  logic          r_err;

  logic [2:0]    w_a_pts;
  logic [2:0]    w_b_pts;
  logic          w_bad;
  logic [1:0]    w_pa;
  logic [1:0]    w_pb;
  logic [2:0]    w_next_idx;
  logic [1:0]    w_na;
  logic [1:0]    w_nb;
  logic [2:0]    w_score_nxt [4];
  logic [2:0]    w_max;
  logic [3:0]    w_win;

  function automatic logic [1:0] pair_first(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: pair_first = 2'd0;
      3'd3, 3'd4:       pair_first = 2'd1;
      3'd5:             pair_first = 2'd2;
      default:          pair_first = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] pair_second(input logic [2:0] idx);
    case (idx)
      3'd0:             pair_second = 2'd1;
      3'd1, 3'd3:       pair_second = 2'd2;
      3'd2, 3'd4, 3'd5: pair_second = 2'd3;
      default:          pair_second = 2'd1;
    endcase
  endfunction

  function automatic logic [2:0] sat_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[3] ? 3'd7 : s[2:0];
  endfunction

  // Credit decode, next-pair selection, score update and winner detection
  always_comb begin
    w_a_pts = 3'd0;
    w_b_pts = 3'd0;
    w_bad   = 1'b0;
    case (cmp_res)
      3'b100: w_a_pts = WIN3;
      3'b010: begin
        w_a_pts = TIE3;
        w_b_pts = TIE3;
      end
      3'b001: w_b_pts = WIN3;
      default: w_bad = 1'b1;
    endcase

    w_pa       = pair_first(r_pair_idx);
    w_pb       = pair_second(r_pair_idx);
    w_next_idx = r_pair_idx + 3'd1;
    w_na       = pair_first(w_next_idx);
    w_nb       = pair_second(w_next_idx);

    for (int i = 0; i < 4; i++) begin
      if (2'(i) == w_pa) begin
        w_score_nxt[i] = sat_add(r_score[i], w_a_pts);
      end else if (2'(i) == w_pb) begin
        w_score_nxt[i] = sat_add(r_score[i], w_b_pts);
      end else begin
        w_score_nxt[i] = r_score[i];
      end
    end

    w_max = r_score[0];
    for (int i = 1; i < 4; i++) begin
      if (r_score[i] > w_max) begin
        w_max = r_score[i];
      end else begin
        w_max = w_max;
      end
    end
    for (int i = 0; i < 4; i++) begin
      w_win[i] = (r_score[i] == w_max);
    end
  end

  // Round sequencer; results persist through IDLE until the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_pair_idx <= 3'd7;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_winners  <= 4'd0;
      r_err      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_score[i] <= 3'd0;
        r_play[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_play[0]  <= J1;
            r_play[1]  <= J2;
            r_play[2]  <= J3;
            r_play[3]  <= J4;
            for (int i = 0; i < 4; i++) begin
              r_score[i] <= 3'd0;
            end
            r_winners  <= 4'd0;
            r_err      <= 1'b0;
            r_op_a     <= J1;
            r_op_b     <= J2;
            r_pair_idx <= 3'd0;
            r_busy     <= 1'b1;
            r_state    <= S_PAIR;
          end
        end
        S_PAIR: begin
          r_score <= w_score_nxt;
          if (w_bad) begin
            r_err <= 1'b1;
          end
          if (r_pair_idx == 3'd5) begin
            r_pair_idx <= 3'd7;
            r_state    <= S_DECIDE;
          end else begin
            r_pair_idx <= w_next_idx;
            r_op_a     <= r_play[w_na];
            r_op_b     <= r_play[w_nb];
          end
        end
        S_DECIDE: begin
          r_winners <= w_win;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign pair_idx = r_pair_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign score1   = r_score[0];
  assign score2   = r_score[1];
  assign score3   = r_score[2];
  assign score4   = r_score[3];
  assign winners  = r_winners;
  assign err      = r_err;

endmodule

// File: tb/tb_round_scheduler.sv
// Directed bench for round_scheduler with a behavioural comparator model.
module tb_round_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] J1, J2, J3, J4;
  logic [2:0] op_a, op_b;
  logic [2:0] pair_idx;
  logic [2:0] cmp_res;
  logic       busy, done;
  logic [2:0] score1, score2, score3, score4;
  logic [3:0] winners;
  logic       err;

  logic       force_bad;
  logic       scramble;
  int         checks = 0;
  int         errors = 0;

  round_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .J1(J1), .J2(J2), .J3(J3), .J4(J4),
    .op_a(op_a), .op_b(op_b), .pair_idx(pair_idx), .cmp_res(cmp_res),
    .busy(busy), .done(done),
    .score1(score1), .score2(score2), .score3(score3), .score4(score4),
    .winners(winners), .err(err)
  );

  always #5 clk = ~clk;

  // Comparator model: higher wins, equal ties; optional corrupt result on pair 0
  always_comb begin
    if (force_bad && pair_idx == 3'd0) cmp_res = 3'b011;
    else if (op_a > op_b)              cmp_res = 3'b100;
    else if (op_a == op_b)             cmp_res = 3'b010;
    else                               cmp_res = 3'b001;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (scramble) begin
      J1 = 3'($urandom); J2 = 3'($urandom); J3 = 3'($urandom); J4 = 3'($urandom);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ops"}, {26'd0, op_a, op_b}, 32'd0);
    chk({tag, "_idx"}, {29'd0, pair_idx}, 32'd7);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_scores"}, {20'd0, score1, score2, score3, score4}, 32'd0);
    chk({tag, "_win_err"}, {27'd0, winners, err}, 32'd0);
  endtask

  // Full round: returns after the done cycle has been checked
  task automatic run_round(input string tag, input logic [2:0] j1, j2, j3, j4,
                           input logic [2:0] e1, e2, e3, e4,
                           input logic [3:0] ewin, input logic eerr);
    int n;
    J1 = j1; J2 = j2; J3 = j3; J4 = j4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd8);
    chk({tag, "_scores"}, {20'd0, score1, score2, score3, score4}, {20'd0, e1, e2, e3, e4});
    chk({tag, "_winners"}, {28'd0, winners}, {28'd0, ewin});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
    chk({tag, "_busy_done_cyc"}, {31'd0, busy}, 32'd1);
  endtask

  logic [2:0] plays [4];
  logic [1:0] exp_a [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  logic [1:0] exp_b [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

  initial begin
    rst = 1'b1; start = 1'b0; force_bad = 1'b0; scramble = 1'b0;
    J1 = 3'd0; J2 = 3'd0; J3 = 3'd0; J4 = 3'd0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    run_round("t1", 3'd0, 3'd0, 3'd7, 3'd7, 3'd1, 3'd1, 3'd5, 3'd5, 4'b1100, 1'b0);
    tick();
    chk("t1_idle_busy", {30'd0, busy, done}, 32'd0);
    tick(); tick();
    chk("t1_hold", {16'd0, score1, score2, score3, score4, winners}, {16'd0, 3'd1, 3'd1, 3'd5, 3'd5, 4'b1100});

    run_round("t2", 3'd7, 3'd7, 3'd7, 3'd7, 3'd3, 3'd3, 3'd3, 3'd3, 4'b1111, 1'b0);
    tick();

    // Pair order walk: operands and index checked in every PAIR cycle
    plays[0] = 3'd7; plays[1] = 3'd0; plays[2] = 3'd0; plays[3] = 3'd0;
    J1 = plays[0]; J2 = plays[1]; J3 = plays[2]; J4 = plays[3];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_pair%0d", k), {23'd0, pair_idx, op_a, op_b},
          {23'd0, 3'(k), plays[exp_a[k]], plays[exp_b[k]]});
      tick();
    end
    chk("t3_decide_idx", {29'd0, pair_idx}, 32'd7);
    tick();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_scores", {20'd0, score1, score2, score3, score4}, {20'd0, 3'd6, 3'd2, 3'd2, 3'd2});
    chk("t3_winners", {28'd0, winners}, 32'b0001);
    tick();

    force_bad = 1'b1;
    run_round("t4", 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 4'b1100, 1'b1);
    force_bad = 1'b0;
    tick();
    chk("t4_err_holds", {31'd0, err}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_cleared", {31'd0, err}, 32'd0);

    // Mid-round reset while pair 3 is active (round started just above)
    tick(); tick(); tick();
    chk("t5_at_pair3", {29'd0, pair_idx}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("t5_rst");

    // start pulse mid-round and in DONE cycle must both be ignored
    J1 = 3'd0; J2 = 3'd0; J3 = 3'd7; J4 = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t5_done_once", {31'd0, done}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_done_start_ign", {30'd0, busy, done}, 32'd0);
    begin
      int extra;
      extra = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (done || busy) extra++;
      end
      chk("t5_no_second_round", extra, 32'd0);
    end
    chk("t5_scores", {16'd0, score1, score2, score3, score4, winners}, {16'd0, 3'd1, 3'd1, 3'd5, 3'd5, 4'b1100});

    // Inputs scrambled every cycle after the start edge
    J1 = 3'd0; J2 = 3'd0; J3 = 3'd7; J4 = 3'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    scramble = 1'b0;
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_scores", {16'd0, score1, score2, score3, score4, winners}, {16'd0, 3'd1, 3'd1, 3'd5, 3'd5, 4'b1100});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
